mmu_xlate: RTL and testbench
============================

# mmu_xlate

Address-translation stage sitting directly upstream of the `tlb` search port: accepts virtual-address requests from the fetch or memory stage, decodes the MIPS32 segment, drives one TLB search port for mapped addresses, and returns a registered physical address, cacheability bit and TLB exception class to the cache/AXI side. A two-entry pipeline (request register + response register) with valid/ready handshakes on both sides decouples the TLB lookup from the consumer. One instance serves instruction fetch and one serves data, each on its own TLB search port.

## Interface
- `TLBNUM`, 16, TLB entry count; `IDXW = $clog2(TLBNUM)`
- `clk`  in  1  clock, all state on rising edge
- `resetn`  in  1  reset, asynchronous, active-low
- `flush`  in  1  exception/ERET flush; kills all in-flight requests
- `tlb_wr_pend`  in  1  a TLBWI/TLBWR is in flight; stage 1 must not evaluate
- `cfg_k0`  in  3  CP0 Config.K0 (kseg0 cacheability)
- `req_valid` / `req_ready`  in / out  1  request handshake
- `req_vaddr`  in  32  virtual address
- `req_wr`  in  1  store access (enables Modified check)
- `req_asid`  in  8  CP0 EntryHi.ASID, sampled at acceptance
- `s_vpn2` out 19, `s_odd_page` out 1, `s_asid` out 8  TLB search request
- `s_found` in 1, `s_index` in IDXW, `s_pfn` in 20, `s_c` in 3, `s_d` in 1, `s_v` in 1  TLB search result (combinational in TLB)
- `rsp_valid` / `rsp_ready`  out / in  1  response handshake
- `rsp_paddr`  out  32  physical address
- `rsp_cached`  out  1  1 = cacheable (C == 3)
- `rsp_ex`  out  1  TLB exception present
- `rsp_excode`  out  2  0 none, 1 refill (miss), 2 invalid, 3 modified
- `rsp_badvaddr`  out  32  original vaddr
- `rsp_wr`  out  1  echo of req_wr

## Operation
- Stage 0 (request register `rq`): captures vaddr, wr, asid on `req_valid && req_ready`.
- Stage 1 (evaluate): combinationally from `rq` only: `s_vpn2 = rq_vaddr[31:13]`, `s_odd_page = rq_vaddr[12]`, `s_asid = rq_asid`. Search port is driven from registers, never from `req_*`.
- Segment decode on `rq_vaddr[31:29]`: 100 kseg0 → paddr `{3'b000, va[28:0]}`, cached = (`cfg_k0 == 3`), no exception; 101 kseg1 → same paddr, cached = 0, no exception; all others mapped.
- Mapped: paddr `{s_pfn, va[11:0]}`, cached = (`s_c == 3`); excode priority: `!s_found` → 1; else `!s_v` → 2; else `rq_wr && !s_d` → 3; else 0. `rsp_ex = (excode != 0)`.
- Result (paddr, cached, ex, excode, badvaddr, wr) registered into response register `rs` on advance.
- `advance = rq_valid && !tlb_wr_pend && (!rs_valid || rsp_ready)`.
- `req_ready = !rq_valid || advance` (combinational; not gated by `flush`, but a request offered during `flush` is dropped).
- `flush`: next edge clears `rq_valid` and `rs_valid`; nothing accepted or advanced that cycle; `rs` payload not required to clear.
- `rs_valid` clears on `rsp_ready && !advance`; holds with stable payload while `!rsp_ready`.

## Timing
- Reset (async, `resetn` low): `rq_valid = 0`, `rs_valid = 0`, `req_ready = 1`, `rsp_valid = 0`, all `rsp_*` payload 0, `s_*` outputs 0.
- Latency: accepted at edge N → `rsp_valid` high after edge N+1 (no stalls).
- Throughput: one request per cycle with `rsp_ready` held high.
- Backpressure: `rsp_ready` low with both registers full → `req_ready` low; payload on `rsp_*` frozen.
- `tlb_wr_pend` high: `rq` holds, no evaluation; resumes the cycle after it drops, seeing the updated TLB.
- Simultaneous accept and advance: `rq` reloads with the new request, `rs` takes the old one.
- `flush` wins over every handshake in the same cycle.
- Reset asserted mid-operation: both valids clear immediately, without waiting for a clock edge.

## Structure
- Shared package `mmu_pkg`: excode constants `EX_NONE/EX_REFILL/EX_INVALID/EX_MOD`, segment codes `SEG_KSEG0 = 3'b100`, `SEG_KSEG1 = 3'b101`, `CACHE_CACHED = 3'd3`.
- One natural sub-module: `seg_decode` (combinational vaddr → unmapped flag, paddr, cached), reused by the cache's uncached-access path.

## Test plan
- kseg1 read 0xBFC0_0000 → paddr 0x1FC0_0000, cached 0, excode 0, rsp_valid one cycle after the accept edge, no TLB lookup used.
- Mapped store va 0x0040_1004, asid 5; TLB entry vpn2 0x00200, asid 5, pfn1 0x12345, v1 1, d1 0 → paddr 0x1234_5004, excode 3, badvaddr 0x0040_1004.
- Mapped load with `s_found = 0` → excode 1; found with v = 0 → excode 2; both with the correct badvaddr.
- Stream of 8 back-to-back requests, `rsp_ready` toggled 1/0 every cycle → all 8 responses in order, none dropped or duplicated, `req_ready` low only when both stages are full.
- `tlb_wr_pend` held 3 cycles with `rq` full while the TLB entry is rewritten → response reflects the new pfn.
- `flush` with both stages full and `resetn` pulsed low mid-stream → `rsp_valid = 0` after the edge (flush) or immediately (reset); next request completes normally.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared definitions for the MMU translation path: exception classes, segment codes
// and the registered response record.
package mmu_pkg;

    localparam logic [1:0] EX_NONE    = 2'd0;
    localparam logic [1:0] EX_REFILL  = 2'd1;
    localparam logic [1:0] EX_INVALID = 2'd2;
    localparam logic [1:0] EX_MOD     = 2'd3;

    localparam logic [2:0] SEG_KSEG0    = 3'b100;
    localparam logic [2:0] SEG_KSEG1    = 3'b101;
    localparam logic [2:0] CACHE_CACHED = 3'd3;

    typedef struct packed {
        logic [31:0] paddr;
        logic        cached;
        logic [1:0]  excode;
        logic [31:0] badvaddr;
        logic        wr;
    } xlate_rsp_t;

    // Miss outranks invalid, which outranks a store to a clean page.
    function automatic logic [1:0] tlb_excode(input logic found, input logic v,
                                              input logic d, input logic wr);
        if (!found)        return EX_REFILL;
        else if (!v)       return EX_INVALID;
        else if (wr && !d) return EX_MOD;
        else               return EX_NONE;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// MIPS32 segment decode: flags kseg0/kseg1 as unmapped and produces their direct
// physical address and cacheability.
module seg_decode
    import mmu_pkg::*;
(
    input  logic [31:0] vaddr,
    input  logic [2:0]  cfg_k0,
    output logic        unmapped,
    output logic [31:0] paddr,
    output logic        cached
);

    logic [2:0] seg;

    always_comb begin
        seg      = vaddr[31:29];
        unmapped = (seg == SEG_KSEG0) || (seg == SEG_KSEG1);
        paddr    = {3'b000, vaddr[28:0]};
        cached   = (seg == SEG_KSEG0) && (cfg_k0 == CACHE_CACHED);
    end

endmodule

// File: rtl/mmu_xlate.sv
// Address-translation stage: request register feeds the TLB search port, result is
// captured in a response register; valid/ready handshakes on both sides.
module mmu_xlate
    import mmu_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            tlb_wr_pend,
    input  logic [2:0]      cfg_k0,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_vaddr,
    input  logic            req_wr,
    input  logic [7:0]      req_asid,
    output logic [18:0]     s_vpn2,
    output logic            s_odd_page,
    output logic [7:0]      s_asid,
    input  logic            s_found,
    input  logic [IDXW-1:0] s_index,
    input  logic [19:0]     s_pfn,
    input  logic [2:0]      s_c,
    input  logic            s_d,
    input  logic            s_v,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_paddr,
    output logic            rsp_cached,
    output logic            rsp_ex,
    output logic [1:0]      rsp_excode,
    output logic [31:0]     rsp_badvaddr,
    output logic            rsp_wr
);

    logic        rq_valid_q, rq_valid_d;
    logic [31:0] rq_vaddr_q, rq_vaddr_d;
    logic        rq_wr_q,    rq_wr_d;
    logic [7:0]  rq_asid_q,  rq_asid_d;
    logic        rs_valid_q, rs_valid_d;
    xlate_rsp_t  rs_q,       rs_d;

    logic        advance;
    logic        accept;
    logic        seg_unmapped;
    logic        seg_cached;
    logic [31:0] seg_paddr;
    xlate_rsp_t  eval_rsp;
    logic        unused_index;

    seg_decode u_seg_decode (
        .vaddr    (rq_vaddr_q),
        .cfg_k0   (cfg_k0),
        .unmapped (seg_unmapped),
        .paddr    (seg_paddr),
        .cached   (seg_cached)
    );

    // The search port only ever sees registered state, keeping req_* off the TLB path.
    assign s_vpn2       = rq_vaddr_q[31:13];
    assign s_odd_page   = rq_vaddr_q[12];
    assign s_asid       = rq_asid_q;
    assign unused_index = ^s_index;

    always_comb begin
        eval_rsp          = '0;
        eval_rsp.badvaddr = rq_vaddr_q;
        eval_rsp.wr       = rq_wr_q;
        if (seg_unmapped) begin
            eval_rsp.paddr  = seg_paddr;
            eval_rsp.cached = seg_cached;
            eval_rsp.excode = EX_NONE;
        end else begin
            eval_rsp.paddr  = {s_pfn, rq_vaddr_q[11:0]};
            eval_rsp.cached = (s_c == CACHE_CACHED);
            eval_rsp.excode = tlb_excode(s_found, s_v, s_d, rq_wr_q);
        end
    end

    // Flush overrides both handshakes; req_ready itself stays ungated.
    always_comb begin
        advance    = rq_valid_q && !tlb_wr_pend && (!rs_valid_q || rsp_ready);
        req_ready  = !rq_valid_q || advance;
        accept     = req_valid && req_ready && !flush;

        rq_valid_d = rq_valid_q;
        rq_vaddr_d = rq_vaddr_q;
        rq_wr_d    = rq_wr_q;
        rq_asid_d  = rq_asid_q;
        rs_valid_d = rs_valid_q;
        rs_d       = rs_q;

        if (flush) begin
            rq_valid_d = 1'b0;
            rs_valid_d = 1'b0;
        end else begin
            if (accept) begin
                rq_valid_d = 1'b1;
                rq_vaddr_d = req_vaddr;
                rq_wr_d    = req_wr;
                rq_asid_d  = req_asid;
            end else if (advance) begin
                rq_valid_d = 1'b0;
            end

            if (advance) begin
                rs_valid_d = 1'b1;
                rs_d       = eval_rsp;
            end else if (rsp_ready) begin
                rs_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rq_valid_q <= 1'b0;
            rq_vaddr_q <= '0;
            rq_wr_q    <= 1'b0;
            rq_asid_q  <= '0;
            rs_valid_q <= 1'b0;
            rs_q       <= '0;
        end else begin
            rq_valid_q <= rq_valid_d;
            rq_vaddr_q <= rq_vaddr_d;
            rq_wr_q    <= rq_wr_d;
            rq_asid_q  <= rq_asid_d;
            rs_valid_q <= rs_valid_d;
            rs_q       <= rs_d;
        end
    end

    assign rsp_valid    = rs_valid_q;
    assign rsp_paddr    = rs_q.paddr;
    assign rsp_cached   = rs_q.cached;
    assign rsp_excode   = rs_q.excode;
    assign rsp_ex       = (rs_q.excode != EX_NONE);
    assign rsp_badvaddr = rs_q.badvaddr;
    assign rsp_wr       = rs_q.wr;

endmodule

// File: tb/tb_mmu_xlate.sv
// Directed bench for mmu_xlate with a small behavioural TLB and an in-order
// scoreboard of expected responses.
module tb_mmu_xlate;
    import mmu_pkg::*;

    localparam int TLBNUM = 16;
    localparam int IDXW   = $clog2(TLBNUM);

    typedef struct {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0, pfn1;
        logic [2:0]  c0, c1;
        logic        v0, v1, d0, d1;
    } tlbe_t;

    logic            clk, resetn, flush, tlb_wr_pend;
    logic [2:0]      cfg_k0;
    logic            req_valid, req_ready, req_wr;
    logic [31:0]     req_vaddr;
    logic [7:0]      req_asid;
    logic [18:0]     s_vpn2;
    logic            s_odd_page;
    logic [7:0]      s_asid;
    logic            s_found, s_d, s_v;
    logic [IDXW-1:0] s_index;
    logic [19:0]     s_pfn;
    logic [2:0]      s_c;
    logic            rsp_valid, rsp_ready, rsp_cached, rsp_ex, rsp_wr;
    logic [31:0]     rsp_paddr, rsp_badvaddr;
    logic [1:0]      rsp_excode;

    tlbe_t      tlb [4];
    xlate_rsp_t exp_q [$];
    xlate_rsp_t pend_exp;
    bit         pend_push;
    bit         toggle_ready;
    bit         check_ready;
    bit         last_acc;
    int         tests_run;
    int         tests_failed;

    mmu_xlate #(.TLBNUM(TLBNUM)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .tlb_wr_pend  (tlb_wr_pend),
        .cfg_k0       (cfg_k0),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_vaddr    (req_vaddr),
        .req_wr       (req_wr),
        .req_asid     (req_asid),
        .s_vpn2       (s_vpn2),
        .s_odd_page   (s_odd_page),
        .s_asid       (s_asid),
        .s_found      (s_found),
        .s_index      (s_index),
        .s_pfn        (s_pfn),
        .s_c          (s_c),
        .s_d          (s_d),
        .s_v          (s_v),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_paddr    (rsp_paddr),
        .rsp_cached   (rsp_cached),
        .rsp_ex       (rsp_ex),
        .rsp_excode   (rsp_excode),
        .rsp_badvaddr (rsp_badvaddr),
        .rsp_wr       (rsp_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural TLB search port; lowest matching index wins, zeros on a miss.
    always_comb begin
        s_found = 1'b0;
        s_index = '0;
        s_pfn   = '0;
        s_c     = '0;
        s_d     = 1'b0;
        s_v     = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (tlb[i].vpn2 == s_vpn2 && (tlb[i].g || tlb[i].asid == s_asid)) begin
                s_found = 1'b1;
                s_index = IDXW'(i);
                s_pfn   = s_odd_page ? tlb[i].pfn1 : tlb[i].pfn0;
                s_c     = s_odd_page ? tlb[i].c1   : tlb[i].c0;
                s_d     = s_odd_page ? tlb[i].d1   : tlb[i].d0;
                s_v     = s_odd_page ? tlb[i].v1   : tlb[i].v0;
            end
        end
    end

    function automatic xlate_rsp_t mk(input logic [31:0] pa, input logic c,
                                      input logic [1:0] ex, input logic [31:0] va,
                                      input logic wr);
        xlate_rsp_t r;
        r.paddr = pa; r.cached = c; r.excode = ex; r.badvaddr = va; r.wr = wr;
        return r;
    endfunction

    // Reference translation built from the bench's own TLB contents.
    function automatic xlate_rsp_t model(input logic [31:0] va, input logic wr,
                                         input logic [7:0] asid);
        logic        hit, odd, v, d;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic [1:0]  ex;
        hit = 1'b0; odd = va[12]; v = 1'b0; d = 1'b0; pfn = '0; c = '0;
        if (va[31:29] == 3'b100) return mk({3'b000, va[28:0]}, cfg_k0 == 3'd3, 2'd0, va, wr);
        if (va[31:29] == 3'b101) return mk({3'b000, va[28:0]}, 1'b0, 2'd0, va, wr);
        for (int i = 3; i >= 0; i--) begin
            if (tlb[i].vpn2 == va[31:13] && (tlb[i].g || tlb[i].asid == asid)) begin
                hit = 1'b1;
                pfn = odd ? tlb[i].pfn1 : tlb[i].pfn0;
                c   = odd ? tlb[i].c1   : tlb[i].c0;
                v   = odd ? tlb[i].v1   : tlb[i].v0;
                d   = odd ? tlb[i].d1   : tlb[i].d0;
            end
        end
        ex = !hit ? 2'd1 : !v ? 2'd2 : (wr && !d) ? 2'd3 : 2'd0;
        return mk({pfn, va[11:0]}, c == 3'd3, ex, va, wr);
    endfunction

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        xlate_rsp_t e;
        tests_run++;
        assert (exp_q.size() != 0) else begin
            tests_failed++;
            $error("[TB] FAIL unexpected_rsp: observed paddr 0x%08h expected no response", rsp_paddr);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            expect_eq("paddr",    rsp_paddr,         e.paddr);
            expect_eq("cached",   32'(rsp_cached),   32'(e.cached));
            expect_eq("excode",   32'(rsp_excode),   32'(e.excode));
            expect_eq("ex",       32'(rsp_ex),       32'(e.excode != 2'd0));
            expect_eq("badvaddr", rsp_badvaddr,      e.badvaddr);
            expect_eq("wr",       32'(rsp_wr),       32'(e.wr));
        end
    endtask

    // One clock: sample at the falling edge, then drive just after the rising edge.
    task automatic tick();
        bit acc;
        @(negedge clk);
        acc = req_valid && req_ready && !flush;
        if (check_ready)
            expect_eq("req_ready", 32'(req_ready), 32'(!(exp_q.size() == 2 && !rsp_ready)));
        if (rsp_valid && rsp_ready) checkOutput();
        if (acc && pend_push) exp_q.push_back(pend_exp);
        @(posedge clk);
        #1;
        last_acc = acc;
        if (toggle_ready) rsp_ready = ~rsp_ready;
    endtask

    task automatic applyStimulus(input logic [31:0] va, input logic wr, input logic [7:0] asid,
                                 input bit push, input xlate_rsp_t e);
        req_valid = 1'b1; req_vaddr = va; req_wr = wr; req_asid = asid;
        pend_exp = e; pend_push = push; last_acc = 1'b0;
        for (int i = 0; i < 20 && !last_acc; i++) tick();
        tests_run++;
        assert (last_acc) else begin
            tests_failed++;
            $error("[TB] FAIL accept_timeout: observed accepted=0 expected accepted=1 va 0x%08h", va);
        end
        req_valid = 1'b0; pend_push = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        expect_eq("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] sva [8];
        logic        swr [8];
        tests_run = 0; tests_failed = 0;
        toggle_ready = 0; check_ready = 0; pend_push = 0; last_acc = 0;
        resetn = 1'b0; flush = 1'b0; tlb_wr_pend = 1'b0; cfg_k0 = 3'd3;
        req_valid = 1'b0; req_vaddr = '0; req_wr = 1'b0; req_asid = '0; rsp_ready = 1'b0;

        tlb[0] = '{vpn2: 19'h00200, asid: 8'd5, g: 1'b0, pfn0: 20'h11111, pfn1: 20'h12345,
                   c0: 3'd2, c1: 3'd3, v0: 1'b1, v1: 1'b1, d0: 1'b1, d1: 1'b0};
        tlb[1] = '{vpn2: 19'h00300, asid: 8'd5, g: 1'b0, pfn0: 20'h0ABCD, pfn1: 20'h0DCBA,
                   c0: 3'd3, c1: 3'd3, v0: 1'b0, v1: 1'b1, d0: 1'b1, d1: 1'b1};
        tlb[2] = '{vpn2: 19'h00100, asid: 8'd0, g: 1'b1, pfn0: 20'h0AAAA, pfn1: 20'h0AAAB,
                   c0: 3'd3, c1: 3'd3, v0: 1'b1, v1: 1'b1, d0: 1'b1, d1: 1'b1};
        tlb[3] = '{vpn2: 19'h5FE00, asid: 8'd0, g: 1'b1, pfn0: 20'h77777, pfn1: 20'h77777,
                   c0: 3'd3, c1: 3'd3, v0: 1'b0, v1: 1'b0, d0: 1'b0, d1: 1'b0};

        #12;
        expect_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        expect_eq("rst_req_ready", 32'(req_ready), 32'd1);
        expect_eq("rst_paddr",     rsp_paddr,      32'd0);
        expect_eq("rst_excode",    32'(rsp_excode), 32'd0);
        expect_eq("rst_badvaddr",  rsp_badvaddr,   32'd0);
        expect_eq("rst_s_vpn2",    32'(s_vpn2),    32'd0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk) #1;

        // kseg1 with one-cycle latency; the matching TLB entry must be ignored.
        applyStimulus(32'hBFC0_0000, 1'b0, 8'd0, 1, mk(32'h1FC0_0000, 1'b0, 2'd0, 32'hBFC0_0000, 1'b0));
        expect_eq("lat_before", 32'(rsp_valid), 32'd0);
        tick();
        expect_eq("lat_after", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        drain();

        applyStimulus(32'h0040_1004, 1'b1, 8'd5, 1, mk(32'h1234_5004, 1'b1, 2'd3, 32'h0040_1004, 1'b1));
        drain();
        applyStimulus(32'h0080_0000, 1'b0, 8'd5, 1, mk(32'h0000_0000, 1'b0, 2'd1, 32'h0080_0000, 1'b0));
        drain();
        applyStimulus(32'h0060_0010, 1'b0, 8'd5, 1, mk(32'h0ABC_D010, 1'b1, 2'd2, 32'h0060_0010, 1'b0));
        drain();
        applyStimulus(32'h8000_1234, 1'b0, 8'd5, 1, mk(32'h0000_1234, 1'b1, 2'd0, 32'h8000_1234, 1'b0));
        drain();
        applyStimulus(32'h0040_1008, 1'b0, 8'd5, 1, mk(32'h1234_5008, 1'b1, 2'd0, 32'h0040_1008, 1'b0));
        drain();
        applyStimulus(32'h0040_1004, 1'b0, 8'd6, 1, mk(32'h0000_0004, 1'b0, 2'd1, 32'h0040_1004, 1'b0));
        drain();

        // Back-to-back stream with rsp_ready toggling every cycle.
        sva = '{32'h8000_0010, 32'hA000_0020, 32'h0040_1000, 32'h0040_0000,
                32'h0060_0004, 32'h0080_0008, 32'h8000_0100, 32'h0040_1FFC};
        swr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        toggle_ready = 1; check_ready = 1;
        for (int i = 0; i < 8; i++)
            applyStimulus(sva[i], swr[i], 8'd5, 1, model(sva[i], swr[i], 8'd5));
        drain();
        toggle_ready = 0; check_ready = 0; rsp_ready = 1'b1;

        // TLB write pending: request held while the entry is rewritten.
        tlb_wr_pend = 1'b1;
        applyStimulus(32'h0020_0040, 1'b0, 8'd9, 0, mk('0, 1'b0, 2'd0, '0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            if (i == 0) tlb[2].pfn0 = 20'h0BBBB;
            expect_eq("wrpend_rsp_valid", 32'(rsp_valid), 32'd0);
            expect_eq("wrpend_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        tlb_wr_pend = 1'b0;
        exp_q.push_back(mk(32'h0BBB_B040, 1'b1, 2'd0, 32'h0020_0040, 1'b0));
        drain();

        // Flush with both stages full; the concurrently offered request is dropped.
        rsp_ready = 1'b0;
        applyStimulus(32'hA000_1000, 1'b0, 8'd5, 1, model(32'hA000_1000, 1'b0, 8'd5));
        applyStimulus(32'h0040_1010, 1'b0, 8'd5, 1, model(32'h0040_1010, 1'b0, 8'd5));
        expect_eq("full_req_ready", 32'(req_ready), 32'd0);
        expect_eq("full_rsp_valid", 32'(rsp_valid), 32'd1);
        flush = 1'b1; req_valid = 1'b1; req_vaddr = 32'hA000_2000;
        tick();
        flush = 1'b0; req_valid = 1'b0;
        expect_eq("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        expect_eq("flush_req_ready", 32'(req_ready), 32'd1);
        exp_q.delete();
        rsp_ready = 1'b1;
        repeat (3) tick();
        applyStimulus(32'hA000_3000, 1'b1, 8'd5, 1, mk(32'h0000_3000, 1'b0, 2'd0, 32'hA000_3000, 1'b1));
        drain();

        // Asynchronous reset mid-stream.
        rsp_ready = 1'b0;
        applyStimulus(32'h8000_4000, 1'b0, 8'd5, 1, model(32'h8000_4000, 1'b0, 8'd5));
        applyStimulus(32'h0040_1004, 1'b0, 8'd5, 1, model(32'h0040_1004, 1'b0, 8'd5));
        #2 resetn = 1'b0;
        #1;
        expect_eq("areset_rsp_valid", 32'(rsp_valid), 32'd0);
        expect_eq("areset_req_ready", 32'(req_ready), 32'd1);
        expect_eq("areset_paddr",     rsp_paddr,      32'd0);
        expect_eq("areset_s_vpn2",    32'(s_vpn2),    32'd0);
        exp_q.delete();
        @(negedge clk) resetn = 1'b1;
        @(posedge clk) #1;
        rsp_ready = 1'b1;
        applyStimulus(32'h0060_1020, 1'b1, 8'd5, 1, mk(32'h0DCB_A020, 1'b1, 2'd0, 32'h0060_1020, 1'b1));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
